// File: rtl/axis_stim_player.sv
// AXI4-Stream stimulus player: replays a preloaded beat store once or in a loop.
// Optional feature macro: AXIS_STIM_PLAYER_GAP_EN adds idle cycles after each handshake.
module axis_stim_player #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW        = $clog2(DEPTH + 1),
    localparam int unsigned KW        = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [KW-1:0]         wr_keep,
    input  logic                  wr_last,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CW-1:0]         num_beats,
    input  logic                  loop_en,
    input  logic [7:0]            gap_cycles,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KW-1:0]         m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           beat_count,
    output logic                  wr_err
);

    typedef struct packed {
        logic                  last;
        logic [KW-1:0]         keep;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [2:0] {StIdle, StFetch, StPlay, StGap, StFlush} state_e;

    // Async assert, sync release: start is honoured from the second edge after release.
    logic rst_sync_q;
    logic rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    assign rst_n = rst_sync_q;

    beat_t         mem [DEPTH];
    state_e        state_q, state_d;
    beat_t         out_q, out_d;
    beat_t         pf_q, pf_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic [AW-1:0] pf_idx_q, pf_idx_d;
    logic [CW-1:0] nb_q, nb_d;
    logic          loop_q, loop_d;
    logic [31:0]   beat_count_q, beat_count_d;
    logic          done_q, done_d;
    logic          wr_err_q, wr_err_d;
`ifdef AXIS_STIM_PLAYER_GAP_EN
    logic [7:0]    gap_q, gap_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
`else
    logic          unused_gap;
    assign unused_gap = ^gap_cycles;
`endif

    logic          busy_w;
    logic          hs;
    logic          is_last;
    logic          advance;
    logic          finish;
    logic          pf_load;
    logic [AW-1:0] pf_addr;
    logic [CW-1:0] nb_start;

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx, input logic [CW-1:0] nb);
        logic [CW-1:0] inc;
        inc = CW'(idx) + CW'(1);
        return (inc >= nb) ? '0 : AW'(inc);
    endfunction

    assign busy_w   = (state_q != StIdle);
    assign hs       = out_valid_q & m_axis_tready;
    assign is_last  = ((CW'(out_idx_q) + CW'(1)) == nb_q);
    assign nb_start = (num_beats > CW'(DEPTH)) ? CW'(DEPTH) : num_beats;

    // Store is deliberately not reset.
    always_ff @(posedge aclk) begin
        if (wr_en && !busy_w) mem[wr_addr] <= {wr_last, wr_keep, wr_data};
    end

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        pf_d         = pf_q;
        pf_idx_d     = pf_idx_q;
        nb_d         = nb_q;
        loop_d       = loop_q;
        beat_count_d = beat_count_q;
        done_d       = 1'b0;
        wr_err_d     = wr_err_q;
        advance      = 1'b0;
        finish       = 1'b0;
        pf_load      = 1'b0;
        pf_addr      = next_idx(pf_idx_q, nb_q);
`ifdef AXIS_STIM_PLAYER_GAP_EN
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
`endif

        if (wr_en && busy_w) wr_err_d = 1'b1;
        if (hs)              beat_count_d = beat_count_q + 32'd1;

        case (state_q)
            StIdle: begin
                if (start) begin
                    wr_err_d     = 1'b0;
                    beat_count_d = '0;
                    if (nb_start == '0) begin
                        done_d = 1'b1;
                    end else begin
                        nb_d    = nb_start;
                        loop_d  = loop_en;
`ifdef AXIS_STIM_PLAYER_GAP_EN
                        gap_d   = gap_cycles;
`endif
                        pf_load = 1'b1;
                        pf_addr = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (stop) begin
                    finish = 1'b1;
                end else begin
                    advance = 1'b1;
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (hs) begin
                    if (stop || (is_last && !loop_q)) finish = 1'b1;
`ifdef AXIS_STIM_PLAYER_GAP_EN
                    else if (gap_q != 8'd0) begin
                        out_valid_d = 1'b0;
                        gap_cnt_d   = gap_q - 8'd1;
                        state_d     = StGap;
                    end
`endif
                    else advance = 1'b1;
                end else if (stop) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (hs) finish = 1'b1;
            end
`ifdef AXIS_STIM_PLAYER_GAP_EN
            StGap: begin
                if (stop) begin
                    finish = 1'b1;
                end else if (gap_cnt_q == 8'd0) begin
                    advance = 1'b1;
                    state_d = StPlay;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Present the prefetched beat and refill the prefetch slot in the same cycle.
        if (advance) begin
            out_d       = pf_q;
            out_idx_d   = pf_idx_q;
            out_valid_d = 1'b1;
            pf_load     = 1'b1;
        end
        if (finish) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = StIdle;
        end
        if (pf_load) begin
            pf_idx_d = pf_addr;
            pf_d     = mem[pf_addr];
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            pf_q         <= '0;
            pf_idx_q     <= '0;
            nb_q         <= '0;
            loop_q       <= 1'b0;
            beat_count_q <= '0;
            done_q       <= 1'b0;
            wr_err_q     <= 1'b0;
`ifdef AXIS_STIM_PLAYER_GAP_EN
            gap_q        <= '0;
            gap_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            pf_q         <= pf_d;
            pf_idx_q     <= pf_idx_d;
            nb_q         <= nb_d;
            loop_q       <= loop_d;
            beat_count_q <= beat_count_d;
            done_q       <= done_d;
            wr_err_q     <= wr_err_d;
`ifdef AXIS_STIM_PLAYER_GAP_EN
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = out_q.keep;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tvalid = out_valid_q;
    assign busy          = busy_w;
    assign done          = done_q;
    assign beat_count    = beat_count_q;
    assign wr_err        = wr_err_q;

endmodule

// File: doc/axis_stim_player.md
AXIS_STIM_PLAYER -- requirements
Module: axis_stim_player

Interface
REQ-001 Parameter DATA_WIDTH, default 64, tdata width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256, number of stored beats; AW = $clog2(DEPTH), CW = $clog2(DEPTH+1).
REQ-003 Ports SHALL be as follows; clock and reset are listed first.
- aclk  in  1  single clock; all logic is on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  beat-store write strobe.
- wr_addr  in  AW  beat-store write index.
- wr_data  in  DATA_WIDTH  stored tdata.
- wr_keep  in  DATA_WIDTH/8  stored tkeep.
- wr_last  in  1  stored tlast.
- start  in  1  one-cycle pulse that begins playback.
- stop  in  1  one-cycle pulse that ends playback.
- num_beats  in  CW  beats per pass, sampled at start.
- loop_en  in  1  repeat the pass until stop, sampled at start.
- gap_cycles  in  8  idle cycles after each handshake, sampled at start.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tkeep  out  DATA_WIDTH/8  stream byte enables.
- m_axis_tlast  out  1  stream end-of-packet.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on pass completion or stop.
- beat_count  out  32  handshakes since the last start; wraps at 2^32.
- wr_err  out  1  sticky; set by a write issued while busy.

Function
REQ-004 The beat store SHALL be DEPTH entries of {data, keep, last}, written synchronously when wr_en=1 and busy=0.
REQ-005 When wr_en=1 and busy=1, the write SHALL be dropped and wr_err SHALL be set; wr_err clears only on reset or on an accepted start.
REQ-006 The FSM SHALL have exactly the states IDLE, FETCH, PLAY, GAP and FLUSH.
REQ-007 In IDLE, start=1 SHALL latch its inputs, clear beat_count and the index, and enter FETCH; start outside IDLE SHALL be ignored.
REQ-008 When the latched num_beats is 0, start SHALL go directly to done=1 with no beat emitted and return to IDLE.
REQ-009 When num_beats > DEPTH, num_beats SHALL be clamped to DEPTH.
REQ-010 The beat at index 0 SHALL be presented with m_axis_tvalid=1 exactly 2 cycles after the start cycle.
REQ-011 Output tdata, tkeep and tlast SHALL come directly from the stored entry; tlast is not synthesised.
REQ-012 Once m_axis_tvalid=1, it and all payload outputs SHALL hold stable until m_axis_tvalid & m_axis_tready.
REQ-013 With tready held at 1 and gap_cycles=0, beats SHALL issue one per cycle with no bubbles; a prefetch register is required.
REQ-014 Each handshake SHALL increment beat_count and the index.
REQ-015 After beat num_beats-1 with loop_en=0: done=1 for one cycle, then IDLE, with tvalid=0 in the following cycle.
REQ-016 After beat num_beats-1 with loop_en=1: the index SHALL wrap to 0 and playback continue with no bubble.
REQ-017 When stop=1 with no beat pending, the block SHALL go to IDLE next cycle with done=1.
REQ-018 When stop=1 with tvalid=1, the block SHALL enter FLUSH, complete that beat's handshake, then pulse done and go to IDLE.
REQ-019 When stop and a handshake occur in the same cycle, that beat SHALL be counted and no further beat issued.

Reset
REQ-020 Assertion of aresetn=0 SHALL immediately force IDLE and set m_axis_tvalid=0, busy=0, done=0, wr_err=0 and beat_count=0.
REQ-021 Reset SHALL also force m_axis_tdata=0, m_axis_tkeep=0 and m_axis_tlast=0.
REQ-022 Beat-store contents SHALL NOT be reset.
REQ-023 Reset mid-playback SHALL abandon the stream without a done pulse.
REQ-024 After release, aresetn SHALL be synchronised; start is accepted from the second rising edge onward.

Configuration
REQ-025 Macro AXIS_STIM_PLAYER_GAP_EN, when defined, SHALL enable the GAP state.
REQ-026 With AXIS_STIM_PLAYER_GAP_EN defined, each handshake SHALL be followed by gap_cycles cycles with tvalid=0 before the next beat.
REQ-027 With AXIS_STIM_PLAYER_GAP_EN undefined, GAP logic SHALL be absent, gap_cycles ignored, and REQ-013 throughput apply unconditionally.
REQ-028 Under AXIS_STIM_PLAYER_GAP_EN, stop during GAP SHALL go to IDLE next cycle with done=1.

Verification
REQ-029 Store 4 beats (data 0x11..0x44, last on beat 3), num_beats=4, tready=1 -> tvalid at start+2, 4 consecutive beats, tlast on the 4th, done one cycle after, beat_count=4.
REQ-030 Same store with tready toggling 1,0,0,1... -> payload stable through stalls, identical beat order, beat_count=4.
REQ-031 loop_en=1, num_beats=3, stop after 7 handshakes, tready=1 -> sequence 0,1,2,0,1,2,0, beat_count=7, done=1.
REQ-032 num_beats=0 -> done at start+1, tvalid never high; num_beats=DEPTH+5 -> exactly DEPTH beats.
REQ-033 wr_en during playback -> wr_err=1 and the store is unchanged; aresetn low mid-stream -> tvalid=0 immediately and no done pulse.
REQ-034 With AXIS_STIM_PLAYER_GAP_EN and gap_cycles=3 -> tvalid rising edges spaced 4 cycles apart under tready=1.
